// File: rtl/dsram_pkg.sv
// Shared types and constants for the data SRAM responder.
// Holds the FSM state enum, write-enable codes and the lane legality helper.
package dsram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WEN_NONE    = 4'b0000;
    localparam logic [3:0] WEN_WORD    = 4'b1111;
    localparam logic [3:0] WEN_HALF_LO = 4'b0011;
    localparam logic [3:0] WEN_HALF_HI = 4'b1100;

    localparam int CNT_W = 4;

    // A write pattern is legal only when its lanes line up with addr[1:0].
    function automatic logic wen_legal(input logic [3:0] wen,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (wen)
            WEN_NONE:    ok = 1'b1;
            WEN_WORD:    ok = (off == 2'd0);
            WEN_HALF_LO: ok = (off == 2'd0);
            WEN_HALF_HI: ok = (off == 2'd2);
            4'b0001:     ok = (off == 2'd0);
            4'b0010:     ok = (off == 2'd1);
            4'b0100:     ok = (off == 2'd2);
            4'b1000:     ok = (off == 2'd3);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dsram_bank.sv
// Word-organised data array with byte-lane writes.
// Exposes the addressed word combinationally and a copy captured at accept.
module dsram_bank
    import dsram_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic [3:0]       wen,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rd_word,
    output logic [31:0]      hold_word
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rd_word = mem[idx];

    // Byte-lane write port; the array is never cleared.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Capture the pre-write word at the accept edge for delayed responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_word <= '0;
        end else if (acc) begin
            hold_word <= mem[idx];
        end
    end

endmodule

// File: rtl/dsram_responder.sv
// Data SRAM responder: accept/wait/respond FSM around dsram_bank.
// Optional misaligned-write check under DSRAM_ALIGN_CHECK_EN.
module dsram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        stallreq_for_mem,
    output logic        busy,
    output logic        addr_err
);
    import dsram_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              is_read;
    logic              pend_read_q;
    logic              ld_rdata;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        wen_eff;
    logic [31:0]       rd_word;
    logic [31:0]       hold_word;
    logic              unused;

    assign idx     = data_sram_addr[IDX_W+1:2];
    assign is_read = (data_sram_wen == WEN_NONE);
    assign accept  = data_sram_en &&
                     ((state_q == IDLE) || (state_q == RESP));

`ifdef DSRAM_ALIGN_CHECK_EN
    logic req_err;
    logic pend_err_q;

    assign req_err = !is_read &&
                     !wen_legal(data_sram_wen, data_sram_addr[1:0]);
    assign wen_eff = req_err ? WEN_NONE : data_sram_wen;

    // Remember whether the accepted write was rejected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_err_q <= 1'b0;
        end else if (accept) begin
            pend_err_q <= req_err;
        end
    end

    assign addr_err = (state_q == RESP) && pend_err_q;
    assign unused   = ^{data_sram_addr[31:IDX_W+2]};
`else
    assign wen_eff  = data_sram_wen;
    assign addr_err = 1'b0;
    assign unused   = ^{data_sram_addr[31:IDX_W+2],
                        data_sram_addr[1:0]};
`endif

    dsram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (resetn),
        .acc       (accept),
        .wen       (wen_eff),
        .idx       (idx),
        .wdata     (data_sram_wdata),
        .rd_word   (rd_word),
        .hold_word (hold_word)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept from IDLE/RESP, count down in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait counter loads at accept and decrements while waiting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Track whether the outstanding request is a read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_read_q <= 1'b0;
        end else if (accept) begin
            pend_read_q <= is_read;
        end
    end

    assign ld_rdata = (WAIT_CYCLES == 0)
                    ? (accept && is_read)
                    : ((state_q == WAIT) && (cnt_q == '0) && pend_read_q);

    // Read data only changes on the edge that enters RESP for a read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= '0;
        end else if (ld_rdata) begin
            data_sram_rdata <= (WAIT_CYCLES == 0) ? rd_word : hold_word;
        end
    end

    assign rdata_valid      = (state_q == RESP) && pend_read_q;
    assign stallreq_for_mem = (state_q == WAIT);
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder with zero and three wait states.
// Alignment expectations follow DSRAM_ALIGN_CHECK_EN when it is defined.
module tb_dsram_responder;

    logic        clk;
    logic        resetn;

    logic        en0, en3;
    logic [3:0]  wen0, wen3;
    logic [31:0] addr0, addr3, wdata0, wdata3;
    logic [31:0] rdata0, rdata3;
    logic        valid0, valid3, stall0, stall3;
    logic        busy0, busy3, err0, err3;

    int vec;
    int miss;

    dsram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk              (clk),
        .resetn           (resetn),
        .data_sram_en     (en0),
        .data_sram_wen    (wen0),
        .data_sram_addr   (addr0),
        .data_sram_wdata  (wdata0),
        .data_sram_rdata  (rdata0),
        .rdata_valid      (valid0),
        .stallreq_for_mem (stall0),
        .busy             (busy0),
        .addr_err         (err0)
    );

    dsram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk              (clk),
        .resetn           (resetn),
        .data_sram_en     (en3),
        .data_sram_wen    (wen3),
        .data_sram_addr   (addr3),
        .data_sram_wdata  (wdata3),
        .data_sram_rdata  (rdata3),
        .rdata_valid      (valid3),
        .stallreq_for_mem (stall3),
        .busy             (busy3),
        .addr_err         (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv3(input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        en3 = e; wen3 = w; addr3 = a; wdata3 = d;
    endtask

    task automatic test_reset();
        vec++;
        if ({rdata0, valid0, stall0, busy0, err0} !== 36'd0) begin
            miss++;
            $display("FAIL reset_w0: got rdata=%h v=%b s=%b b=%b e=%b want all 0",
                     rdata0, valid0, stall0, busy0, err0);
        end
        vec++;
        if ({rdata3, valid3, stall3, busy3, err3} !== 36'd0) begin
            miss++;
            $display("FAIL reset_w3: got rdata=%h v=%b s=%b b=%b e=%b want all 0",
                     rdata3, valid3, stall3, busy3, err3);
        end
    endtask

    task automatic test_write_read();
        drv0(1, 4'hF, 32'h10, 32'hDEADBEEF);
        step();
        vec++;
        if (valid0 !== 1'b0 || stall0 !== 1'b0 || busy0 !== 1'b1) begin
            miss++;
            $display("FAIL wr_resp: got v=%b s=%b b=%b want 0 0 1",
                     valid0, stall0, busy0);
        end
        drv0(1, 4'h0, 32'h10, 32'h0);
        step();
        vec++;
        if (rdata0 !== 32'hDEADBEEF || valid0 !== 1'b1 || stall0 !== 1'b0) begin
            miss++;
            $display("FAIL rd_resp: got rdata=%h v=%b s=%b want deadbeef 1 0",
                     rdata0, valid0, stall0);
        end
        drv0(0, 4'h0, 32'h0, 32'h0);
        step();
        vec++;
        if (rdata0 !== 32'hDEADBEEF || valid0 !== 1'b0 || busy0 !== 1'b0) begin
            miss++;
            $display("FAIL rd_idle: got rdata=%h v=%b b=%b want deadbeef 0 0",
                     rdata0, valid0, busy0);
        end
    endtask

    task automatic test_byte_lane();
        drv0(1, 4'hF, 32'h20, 32'h11223344);
        step();
        drv0(1, 4'h2, 32'h21, 32'h0000AA00);
        step();
        drv0(1, 4'h0, 32'h20, 32'h0);
        step();
        vec++;
        if (rdata0 !== 32'h1122AA44 || valid0 !== 1'b1) begin
            miss++;
            $display("FAIL byte_lane: got rdata=%h v=%b want 1122aa44 1",
                     rdata0, valid0);
        end
        drv0(0, 4'h0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h0A0A0A0A;
        exp[1] = 32'h0B0B0B0B;
        exp[2] = 32'h0C0C0C0C;
        for (int i = 0; i < 3; i++) begin
            drv0(1, 4'hF, 32'(i * 4), exp[i]);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drv0(1, 4'h0, 32'(i * 4), 32'h0);
            step();
            vec++;
            if (rdata0 !== exp[i] || valid0 !== 1'b1 || busy0 !== 1'b1) begin
                miss++;
                $display("FAIL b2b_%0d: got rdata=%h v=%b b=%b want %h 1 1",
                         i, rdata0, valid0, busy0, exp[i]);
            end
        end
        drv0(0, 4'h0, 32'h0, 32'h0);
        step();
        vec++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
            miss++;
            $display("FAIL b2b_end: got v=%b b=%b want 0 0", valid0, busy0);
        end
    endtask

    task automatic test_wait_states();
        int n_stall;
        int n_busy;
        drv3(1, 4'hF, 32'h10, 32'hCAFEF00D);
        step();
        drv3(0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) step();
        drv3(1, 4'h0, 32'h10, 32'h0);
        n_stall = 0;
        n_busy  = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) drv3(0, 4'h0, 32'h0, 32'h0);
            if (stall3 === 1'b1) n_stall++;
            if (busy3 === 1'b1) n_busy++;
            vec++;
            if (valid3 !== (k == 4)) begin
                miss++;
                $display("FAIL wait_valid_c%0d: got %b want %b",
                         k, valid3, (k == 4));
            end
            if (k == 4) begin
                vec++;
                if (rdata3 !== 32'hCAFEF00D) begin
                    miss++;
                    $display("FAIL wait_rdata: got %h want cafef00d", rdata3);
                end
            end
            if (k == 2) begin
                vec++;
                if (rdata3 !== 32'h0) begin
                    miss++;
                    $display("FAIL wait_hold: got %h want 00000000", rdata3);
                end
            end
        end
        vec++;
        if (n_stall !== 3 || n_busy !== 4) begin
            miss++;
            $display("FAIL wait_counts: got stall=%0d busy=%0d want 3 4",
                     n_stall, n_busy);
        end
    endtask

    task automatic test_reset_in_wait();
        drv3(1, 4'hF, 32'h40, 32'h5A5A1234);
        step();
        drv3(0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) step();
        drv3(1, 4'h0, 32'h40, 32'h0);
        step();
        drv3(0, 4'h0, 32'h0, 32'h0);
        step();
        resetn = 1'b0;
        #1;
        vec++;
        if (stall3 !== 1'b0 || busy3 !== 1'b0 || valid3 !== 1'b0) begin
            miss++;
            $display("FAIL rst_wait: got s=%b b=%b v=%b want 0 0 0",
                     stall3, busy3, valid3);
        end
        step();
        #2;
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            vec++;
            if (valid3 !== 1'b0) begin
                miss++;
                $display("FAIL rst_novalid_c%0d: got %b want 0", k, valid3);
            end
        end
        drv3(1, 4'h0, 32'h40, 32'h0);
        step();
        drv3(0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) step();
        vec++;
        if (rdata3 !== 32'h5A5A1234 || valid3 !== 1'b1) begin
            miss++;
            $display("FAIL rst_keep: got rdata=%h v=%b want 5a5a1234 1",
                     rdata3, valid3);
        end
        step();
    endtask

    task automatic test_align_alias();
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DSRAM_ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'h01020304;
`else
        exp_err  = 1'b0;
        exp_word = 32'hFFFFFFFF;
`endif
        drv0(1, 4'hF, 32'h10, 32'h01020304);
        step();
        drv0(1, 4'hF, 32'h12, 32'hFFFFFFFF);
        step();
        vec++;
        if (err0 !== exp_err) begin
            miss++;
            $display("FAIL align_err: got %b want %b", err0, exp_err);
        end
        drv0(1, 4'h0, 32'h10, 32'h0);
        step();
        vec++;
        if (err0 !== 1'b0 || rdata0 !== exp_word) begin
            miss++;
            $display("FAIL align_data: got e=%b rdata=%h want 0 %h",
                     err0, rdata0, exp_word);
        end
        drv0(1, 4'h4, 32'h12, 32'h00770000);
        step();
        vec++;
        if (err0 !== 1'b0) begin
            miss++;
            $display("FAIL align_lane_err: got %b want 0", err0);
        end
        drv0(1, 4'h0, 32'h10, 32'h0);
        step();
        vec++;
        if (rdata0 !== ((exp_word & 32'hFF00FFFF) | 32'h00770000)) begin
            miss++;
            $display("FAIL align_lane_data: got %h want %h", rdata0,
                     (exp_word & 32'hFF00FFFF) | 32'h00770000);
        end
        drv0(1, 4'hF, 32'h1010, 32'h13572468);
        step();
        drv0(1, 4'h0, 32'h1012, 32'h0);
        step();
        vec++;
        if (rdata0 !== 32'h13572468 || valid0 !== 1'b1 || err0 !== 1'b0) begin
            miss++;
            $display("FAIL alias: got rdata=%h v=%b e=%b want 13572468 1 0",
                     rdata0, valid0, err0);
        end
        drv0(0, 4'h0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        vec    = 0;
        miss   = 0;
        resetn = 1'b0;
        drv0(0, 4'h0, 32'h0, 32'h0);
        drv3(0, 4'h0, 32'h0, 32'h0);
        #3;
        test_reset();
        #9;
        resetn = 1'b1;
        step();
        test_write_read();
        test_byte_lane();
        test_back_to_back();
        test_wait_states();
        test_reset_in_wait();
        test_align_alias();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
